// File: rtl/mem_arb_pkg.sv
// Shared types and parameter defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

   typedef enum logic {IDLE, WAIT} state_t;
   typedef enum logic {OWN_IF, OWN_D} own_t;

   localparam int ADDR_W_DEF     = 32;
   localparam int DATA_W_DEF     = 32;
   localparam int MEM_LAT_DEF    = 2;
   localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory bus bundle for the arbiter.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              m_req;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata,
      output m_req, m_we, m_addr, m_wdata,
      input  m_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  m_req, m_we, m_addr, m_wdata,
      output m_rdata
   );

endinterface

// File: rtl/mem_arbiter_prio.sv
// Data-over-fetch priority with a saturating starvation counter.
module arb_prio
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic if_req,
   input  logic d_req,
   input  logic go,
   output own_t own
);

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   logic [3:0] starve;

   assign own = (if_req && (!d_req || starve == SMAX))
              ? OWN_IF : OWN_D;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve <= '0;
      end else if (go) begin
         if (own == OWN_D && if_req) begin
            starve <= (starve == SMAX) ? starve : starve + 4'd1;
         end else begin
            starve <= '0;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for a fetch and a data requester.
// One transaction in flight; the grant is combinational in IDLE.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int MEM_LAT    = MEM_LAT_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   state_t            state;
   own_t              own;
   own_t              owner;
   logic              go;
   logic              if_g;
   logic              d_g;
   logic [2:0]        cnt;
   logic              if_rv_q;
   logic              d_rv_q;
   logic [DATA_W-1:0] if_rd_q;
   logic [DATA_W-1:0] d_rd_q;
   logic [ADDR_W-1:0] addr_sel;

   assign go = (state == IDLE) && (bus.if_req || bus.d_req);

   arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .clk    (clk),
      .reset  (reset),
      .if_req (bus.if_req),
      .d_req  (bus.d_req),
      .go     (go),
      .own    (own)
   );

   assign if_g     = go && (own == OWN_IF);
   assign d_g      = go && (own == OWN_D);
   assign addr_sel = d_g ? bus.d_addr : bus.if_addr;

   assign bus.if_gnt    = if_g;
   assign bus.d_gnt     = d_g;
   assign bus.m_req     = go;
   assign bus.m_we      = d_g && bus.d_we;
   assign bus.m_addr    = addr_sel;
   assign bus.m_wdata   = bus.d_wdata;
   assign bus.if_rvalid = if_rv_q;
   assign bus.if_rdata  = if_rd_q;
   assign bus.d_rvalid  = d_rv_q;
   assign bus.d_rdata   = d_rd_q;

   // cnt reaches 1 in the cycle memory data is valid
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         owner   <= OWN_IF;
         cnt     <= '0;
         if_rv_q <= 1'b0;
         d_rv_q  <= 1'b0;
         if_rd_q <= '0;
         d_rd_q  <= '0;
      end else begin
         if_rv_q <= 1'b0;
         d_rv_q  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (go) begin
                  state <= WAIT;
                  cnt   <= 3'(MEM_LAT);
                  owner <= own;
               end
            end
            WAIT: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) begin
                  state <= IDLE;
                  if (owner == OWN_D) begin
                     d_rd_q <= bus.m_rdata;
                     d_rv_q <= 1'b1;
                  end else begin
                     if_rd_q <= bus.m_rdata;
                     if_rv_q <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports.
REQ-003 Parameter MEM_LAT, default 2, fixed memory read latency in cycles (legal range 1..7).
REQ-004 Parameter STARVE_MAX, default 4, consecutive data grants allowed while fetch waits (legal range 1..15).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-007 if_req  in  1  fetch requester wants a read.
REQ-008 if_addr  in  ADDR_W  fetch address.
REQ-009 if_gnt  out  1  fetch request accepted this cycle.
REQ-010 if_rvalid  out  1  one-cycle pulse; if_rdata valid.
REQ-011 if_rdata  out  DATA_W  fetch read data.
REQ-012 d_req  in  1  data requester wants an access.
REQ-013 d_we  in  1  data access is a write.
REQ-014 d_addr  in  ADDR_W  data address.
REQ-015 d_wdata  in  DATA_W  write data.
REQ-016 d_gnt  out  1  data request accepted this cycle.
REQ-017 d_rvalid  out  1  one-cycle pulse; read data valid, or write acknowledge.
REQ-018 d_rdata  out  DATA_W  data read data.
REQ-019 m_req  out  1  single-port memory access strobe.
REQ-020 m_we  out  1  memory write enable.
REQ-021 m_addr  out  ADDR_W  memory address.
REQ-022 m_wdata  out  DATA_W  memory write data.
REQ-023 m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after m_req.

Function
REQ-024 FSM states: IDLE, WAIT; at most one transaction outstanding.
REQ-025 In IDLE with if_req or d_req high: same-cycle combinational grant, m_req=1, state goes to WAIT; this is acceptance cycle T.
REQ-026 Exactly one of if_gnt/d_gnt pulses at T; gnt is never asserted in WAIT.
REQ-027 m_addr/m_we/m_wdata driven from the granted port at T only; m_we=0 on fetch grants; when m_req=0, m_we=0 and the other memory outputs are don't-care.
REQ-028 WAIT: a down-counter loaded with MEM_LAT at T; m_rdata is captured into the granted port's rdata register at T+MEM_LAT.
REQ-029 The granted port's rvalid pulses at T+MEM_LAT+1 (writes included); FSM is in IDLE in that cycle, so a new grant may occur in the same cycle (throughput 1 per MEM_LAT+1 cycles).
REQ-030 The rdata registers hold their value until the next capture for the same port.
REQ-031 Priority: data wins over fetch, unless starve_cnt==STARVE_MAX and if_req=1, in which case fetch wins.
REQ-032 starve_cnt increments (saturating at STARVE_MAX) on each data grant made while if_req=1.
REQ-033 starve_cnt clears on a fetch grant, and on any grant made while if_req=0.
REQ-034 Requesters hold req/address/data stable until gnt; the arbiter need not latch inputs before T.
REQ-035 A requester dropping req before gnt: no transaction and no rvalid for that port.
REQ-036 Addresses pass through unmodified; no alignment checking.

Reset
REQ-037 Reset low: state=IDLE, counters=0, starve_cnt=0, all gnt/rvalid/m_req/m_we=0, rdata registers=0.
REQ-038 Reset asserted mid-WAIT aborts the transaction; no rvalid is issued for it after release.
REQ-039 First grant is possible in the first rising edge cycle after reset deasserts.

Structure
REQ-040 Shared package mem_arb_pkg holds the state enum (IDLE, WAIT), a grant-owner enum (OWN_IF, OWN_D) and the parameter defaults.
REQ-041 The starvation counter and priority decision form one sub-module, arb_prio, instantiated once.

Verification
REQ-042 Single fetch: if_req=1, if_addr=0x10, m_rdata=0xDEADBEEF at T+2 -> if_gnt at T, m_addr=0x10, if_rvalid at T+3 with if_rdata=0xDEADBEEF.
REQ-043 Collision: if_req=d_req=1 at T, d_we=1, d_addr=0x40, d_wdata=0x55 -> d_gnt at T, m_we=1, m_wdata=0x55; d_rvalid at T+3; if_gnt at T+3.
REQ-044 Starvation: d_req and if_req held high continuously -> 4 data grants, then 1 fetch grant, pattern repeating.
REQ-045 Reset mid-op: reset=0 at T+1 of a read, released at T+2 -> no rvalid; outputs zero; next request granted normally.
REQ-046 Back-to-back: d_req held high for reads at 0x0, 0x4, 0x8 -> grants spaced 3 cycles apart; d_rdata is correct for each read.
REQ-047 Withdrawn request: if_req pulsed for one cycle while in WAIT -> no if_gnt and no if_rvalid.
